// File: rtl/digest_unpacker.sv
// digest_unpacker: buffers one SHA-256 digest and streams it to uart_tx,
// one character per DV/Done handshake, as raw bytes or lowercase hex.
// Ports:
//   clk, rst        : clock, async active-high reset
//   hash_word_in    : digest word from the core, H0 first
//   hash_valid_in   : hash_word_in valid this cycle
//   Tx_Done_in      : uart_tx finished the current byte
//   tx_byte_out     : byte to uart_tx, held from DV until Done
//   Tx_DV_out       : one-cycle start request to uart_tx
//   busy_out        : high whenever not idle
//   done_out        : one-cycle pulse after the last character
//   overrun_out     : sticky, a word arrived while transmitting
module digest_unpacker #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 8,
  parameter int HEX_ASCII  = 0,
  parameter int APPEND_NL  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] hash_word_in,
  input  logic                  hash_valid_in,
  input  logic                  Tx_Done_in,
  output logic [7:0]            tx_byte_out,
  output logic                  Tx_DV_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  overrun_out
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_WAIT_TX = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam int NCHAR = (HEX_ASCII != 0)
    ? (8 * NUM_WORDS + ((APPEND_NL != 0) ? 1 : 0))
    : (4 * NUM_WORDS);
  localparam logic [6:0] LAST   = 7'(NCHAR - 1);
  localparam logic [6:0] NL_IDX = 7'(8 * NUM_WORDS);
  localparam logic [2:0] WLAST  = 3'(NUM_WORDS - 1);

  logic [2:0]            r_state;
  logic [2:0]            r_word_cnt;
  logic [6:0]            r_char_cnt;
  logic [DATA_WIDTH-1:0] r_buf [NUM_WORDS];
  logic [7:0]            r_tx_byte;
  logic                  r_overrun;

  logic [2:0]            w_widx;
  logic [1:0]            w_bidx;
  logic [DATA_WIDTH-1:0] w_word;
  logic [7:0]            w_byte;
  logic [3:0]            w_nib;
  logic [7:0]            w_hex;
  logic [7:0]            w_char;
  logic                  w_capturing;

  // Character index -> word/byte/nibble. Hex mode spends two
  // characters per byte, so the byte index shifts up one bit.
  always_comb begin
    w_widx = (HEX_ASCII != 0) ? r_char_cnt[5:3] : r_char_cnt[4:2];
    w_bidx = (HEX_ASCII != 0) ? r_char_cnt[2:1] : r_char_cnt[1:0];
    w_word = r_buf[w_widx];
    w_byte = 8'h00;
    case (w_bidx)
      2'd0:    w_byte = w_word[31:24];
      2'd1:    w_byte = w_word[23:16];
      2'd2:    w_byte = w_word[15:8];
      default: w_byte = w_word[7:0];
    endcase
    // Even character = high nibble.
    w_nib = r_char_cnt[0] ? w_byte[3:0] : w_byte[7:4];
    // 'a' - 10 = 0x57
    w_hex = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib})
                            : (8'h57 + {4'h0, w_nib});
    if (HEX_ASCII == 0)
      w_char = w_byte;
    else if ((APPEND_NL != 0) && (r_char_cnt == NL_IDX))
      w_char = 8'h0A;
    else
      w_char = w_hex;
  end

  assign w_capturing = (r_state == S_IDLE) || (r_state == S_CAPTURE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_word_cnt <= 3'd0;
      r_char_cnt <= 7'd0;
      r_tx_byte  <= 8'h00;
      r_overrun  <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++)
        r_buf[i] <= '0;
    end else begin
      // Words arriving mid-transfer are dropped but flagged.
      if (hash_valid_in && !w_capturing)
        r_overrun <= 1'b1;
      case (r_state)
        S_IDLE, S_CAPTURE: begin
          if (hash_valid_in) begin
            r_buf[r_word_cnt] <= hash_word_in;
            if (r_state == S_IDLE)
              r_overrun <= 1'b0;
            if (r_word_cnt == WLAST) begin
              r_word_cnt <= 3'd0;
              r_state    <= S_LOAD;
            end else begin
              r_word_cnt <= r_word_cnt + 3'd1;
              r_state    <= S_CAPTURE;
            end
          end
        end
        S_LOAD: begin
          r_tx_byte <= w_char;
          r_state   <= S_SEND;
        end
        S_SEND: r_state <= S_WAIT_TX;
        S_WAIT_TX: begin
          if (Tx_Done_in) begin
            if (r_char_cnt == LAST) begin
              r_state <= S_DONE;
            end else begin
              r_char_cnt <= r_char_cnt + 7'd1;
              r_state    <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          r_char_cnt <= 7'd0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Decoded from state so an async reset drops them at once.
  assign Tx_DV_out   = (r_state == S_SEND);
  assign busy_out    = (r_state != S_IDLE);
  assign done_out    = (r_state == S_DONE);
  assign tx_byte_out = r_tx_byte;
  assign overrun_out = r_overrun;

endmodule
